module_lpf_iir_biquad: RTL and testbench
========================================

Name: module_lpf_iir_biquad

Overview:
- Sample-rate biquad IIR low-pass filter, directly downstream of the LPF coefficient calculator.
- Consumes the calculator's 5-coefficient flat bus and its calc_done pulse.
- Filters one 18-bit voice sample per valid/ready handshake using a single time-multiplexed multiply-accumulate (5 MAC cycles per sample).
- Coefficient swaps and history clears are applied only between samples, so no sample ever mixes old and new coefficients.

Parameters:
- COEF_FRAC, 15: fractional bits of coefficients (Q2.15, range [-4.0, 4.0)).
- ACC_W, 48: accumulator width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- coefs_flat  in  90  [17:0]=b0, [35:18]=b1, [53:36]=b2, [71:54]=a1, [89:72]=a2; all signed
- coefs_update  in  1  one-cycle pulse (calc_done); coefs_flat is valid in this cycle
- state_clear  in  1  one-cycle pulse; zero the filter history
- sample_in  in  18  signed input sample, Q1.17
- sample_in_valid  in  1  input sample valid
- sample_in_ready  out  1  block can accept a sample
- sample_out  out  18  signed filtered sample, Q1.17
- sample_out_valid  out  1  one-cycle pulse; sample_out is valid

Behaviour:
- Transfer function: y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2. x1/x2 are the previous inputs; y1/y2 are the previous saturated outputs.
- Reset (reset==0 at a clk edge), including mid-operation:
  - state returns to IDLE; MAC and counter are abandoned.
  - sample_out=0, sample_out_valid=0, sample_in_ready=1.
  - active and shadow coefficients = 0; x1, x2, y1, y2 = 0; pending flags cleared.
- States: IDLE, MAC, OUT.
- IDLE:
  - sample_in_ready=1.
  - On an edge with sample_in_valid=1: latch x=sample_in, clear the accumulator, cnt=0, go to MAC.
- MAC:
  - sample_in_ready=0.
  - Each cycle: acc += coef[cnt]*operand[cnt], cnt+1.
  - Term order: b0*x, b1*x1, b2*x2, -a1*y1, -a2*y2. Subtraction uses a negated product, not a negated coefficient, so -4.0 coefficients are valid.
  - Products are 36-bit signed, sign-extended to ACC_W.
  - After cnt==4 is accumulated, go to OUT.
- OUT (one cycle, then IDLE):
  - r = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC (arithmetic shift).
  - Saturate r to [-131072, 131071].
  - Register sample_out, pulse sample_out_valid.
  - Shift history: x2<=x1, x1<=x, y2<=y1, y1<=saturated y.
- Latency and throughput:
  - Sample accepted at edge E; sample_out_valid high in the cycle following edge E+6.
  - sample_in_ready=1 again in that same cycle.
  - Throughput: one sample per 7 cycles.
  - sample_out holds its value until the next OUT.
- Coefficient update:
  - coefs_update in any state copies coefs_flat into the shadow register and sets coef_pending.
  - On any edge in IDLE with coef_pending, or with coefs_update in that cycle, active <= new coefficients and coef_pending cleared.
  - A sample accepted on the same edge as coefs_update uses the new coefficients.
  - An update during MAC/OUT takes effect for the next sample only; the last update wins.
- state_clear:
  - In IDLE, x1/x2/y1/y2 are zeroed at that edge. A sample accepted on the same edge sees zero history.
  - In MAC/OUT it sets clear_pending and is applied at the first IDLE edge. The OUT-cycle history shift of the in-flight sample is then overwritten by the clear.
- sample_in_valid while busy: ignored; upstream holds the sample until ready.
- sample_out_valid is never asserted without a preceding accepted sample.

Test Plan:
1. Passthrough: b0=32768, others 0, coefs_update; send 1000 -> sample_out=1000, valid 7 cycles after acceptance; send -2000 -> -2000.
2. Delay and feedback:
   - b1=32768 only; impulse 5000, 0, 0 -> outputs 0, 5000, 0.
   - Then b0=32768, a1=-16384; state_clear; impulse 8192, 0, 0, 0 -> 8192, 4096, 2048, 1024.
3. Saturation and rounding:
   - b0=98304 (3.0); 100000 -> 131071; -100000 -> -131072.
   - Then b0=16384 (0.5); 3 -> 2 (round half up); -3 -> -1.
4. Mid-sample coefficient update: b0=32768 active; accept 1000; pulse coefs_update with b0=65536 during MAC -> output 1000; next sample 1000 -> 2000.
5. Handshake: hold sample_in_valid high continuously -> exactly one acceptance per 7 cycles; sample_in_ready low in every MAC/OUT cycle.
6. Reset mid-MAC: drive reset=0 for one cycle during MAC -> no sample_out_valid pulse for that sample, sample_out=0, ready=1 next cycle; then sample 1000 with no coefs_update -> output 0 (coefficients zeroed).

Source files
------------

// File: rtl/module_lpf_iir_biquad.sv
// Biquad IIR low-pass: one 18-bit sample per handshake, evaluated with a single
// shared MAC over five cycles; coefficient swaps and history clears land only between samples.
module module_lpf_iir_biquad #(
  parameter int COEF_FRAC = 15,
  parameter int ACC_W     = 48
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [89:0]        coefs_flat,
  input  logic               coefs_update,
  input  logic               state_clear,
  input  logic signed [17:0] sample_in,
  input  logic               sample_in_valid,
  output logic               sample_in_ready,
  output logic signed [17:0] sample_out,
  output logic               sample_out_valid
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  localparam logic signed [ACC_W-1:0] ROUND   = ACC_W'(1) <<< (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(131071);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-131072);

  state_t                    r_state;
  logic [89:0]               r_coef_active;
  logic [89:0]               r_coef_shadow;
  logic                      r_coef_pending;
  logic                      r_clear_pending;
  logic signed [17:0]        r_x;
  logic signed [17:0]        r_x1;
  logic signed [17:0]        r_x2;
  logic signed [17:0]        r_y1;
  logic signed [17:0]        r_y2;
  logic [2:0]                r_cnt;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_ready;
  logic                      r_valid;
  logic signed [17:0]        r_out;

  logic signed [17:0]        w_coef [5];
  logic signed [17:0]        w_coef_sel;
  logic signed [17:0]        w_operand;
  logic                      w_subtract;
  logic signed [35:0]        w_product;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_term;
  logic signed [ACC_W-1:0]   w_rounded;
  logic signed [ACC_W-1:0]   w_shifted;
  logic signed [17:0]        w_sat;
  logic [89:0]               w_coef_next;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_coef
      assign w_coef[gi] = r_coef_active[gi*18 +: 18];
    end
  endgenerate

  always_comb begin
    w_coef_sel = w_coef[0];
    w_operand  = r_x;
    w_subtract = 1'b0;
    case (r_cnt)
      3'd1: begin w_coef_sel = w_coef[1]; w_operand = r_x1; end
      3'd2: begin w_coef_sel = w_coef[2]; w_operand = r_x2; end
      3'd3: begin w_coef_sel = w_coef[3]; w_operand = r_y1; w_subtract = 1'b1; end
      3'd4: begin w_coef_sel = w_coef[4]; w_operand = r_y2; w_subtract = 1'b1; end
      default: ;
    endcase
  end

  // Feedback terms negate the widened product so a -4.0 coefficient stays exact.
  assign w_product  = w_coef_sel * w_operand;
  assign w_prod_ext = {{(ACC_W-36){w_product[35]}}, w_product};
  assign w_term     = w_subtract ? -w_prod_ext : w_prod_ext;

  assign w_rounded = r_acc + ROUND;
  assign w_shifted = w_rounded >>> COEF_FRAC;

  always_comb begin
    if (w_shifted > SAT_MAX)      w_sat = 18'h1FFFF;
    else if (w_shifted < SAT_MIN) w_sat = 18'h20000;
    else                          w_sat = w_shifted[17:0];
  end

  assign w_coef_next = coefs_update ? coefs_flat : r_coef_shadow;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_coef_active   <= '0;
      r_coef_shadow   <= '0;
      r_coef_pending  <= 1'b0;
      r_clear_pending <= 1'b0;
      r_x             <= '0;
      r_x1            <= '0;
      r_x2            <= '0;
      r_y1            <= '0;
      r_y2            <= '0;
      r_cnt           <= '0;
      r_acc           <= '0;
      r_ready         <= 1'b1;
      r_valid         <= 1'b0;
      r_out           <= '0;
    end else begin
      r_valid <= 1'b0;
      if (coefs_update) begin
        r_coef_shadow  <= coefs_flat;
        r_coef_pending <= 1'b1;
      end
      if (state_clear) r_clear_pending <= 1'b1;

      case (r_state)
        IDLE: begin
          if (coefs_update || r_coef_pending) begin
            r_coef_active  <= w_coef_next;
            r_coef_pending <= 1'b0;
          end
          // Clearing here also wipes the history shift done by the previous OUT.
          if (state_clear || r_clear_pending) begin
            r_x1            <= '0;
            r_x2            <= '0;
            r_y1            <= '0;
            r_y2            <= '0;
            r_clear_pending <= 1'b0;
          end
          if (sample_in_valid) begin
            r_x     <= sample_in;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= MAC;
          end
        end
        MAC: begin
          r_acc <= r_acc + w_term;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd4) r_state <= OUT;
        end
        OUT: begin
          r_out   <= w_sat;
          r_valid <= 1'b1;
          r_x2    <= r_x1;
          r_x1    <= r_x;
          r_y2    <= r_y1;
          r_y1    <= w_sat;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign sample_in_ready  = r_ready;
  assign sample_out       = r_out;
  assign sample_out_valid = r_valid;

endmodule

// File: tb/tb_module_lpf_iir_biquad.sv
// Scoreboard bench for the biquad: stimulus pushes model outputs, a monitor pops
// and compares them (value and cycle of arrival) whenever sample_out_valid pulses.
module tb_module_lpf_iir_biquad;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [89:0]        coefs_flat = '0;
  logic               coefs_update = 1'b0;
  logic               state_clear = 1'b0;
  logic signed [17:0] sample_in = '0;
  logic               sample_in_valid = 1'b0;
  logic               sample_in_ready;
  logic signed [17:0] sample_out;
  logic               sample_out_valid;

  module_lpf_iir_biquad #(.COEF_FRAC(15), .ACC_W(48)) dut (
    .clk              (clk),
    .reset            (reset),
    .coefs_flat       (coefs_flat),
    .coefs_update     (coefs_update),
    .state_clear      (state_clear),
    .sample_in        (sample_in),
    .sample_in_valid  (sample_in_valid),
    .sample_in_ready  (sample_in_ready),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    int y;
    int at_cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: coefficients and history as plain integers.
  int  m_b0, m_b1, m_b2, m_a1, m_a2;
  int  m_x1, m_x2, m_y1, m_y2;
  bit  m_clear_req;

  function automatic void check(input bit ok, input string name, input longint act, input longint req);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endfunction

  function automatic void model_reset();
    m_b0 = 0; m_b1 = 0; m_b2 = 0; m_a1 = 0; m_a2 = 0;
    m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
    m_clear_req = 0;
    exp_q.delete();
  endfunction

  function automatic void model_accept(input int x, input int at_cyc);
    longint acc;
    longint r;
    exp_t   e;
    if (m_clear_req) begin
      m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
      m_clear_req = 0;
    end
    acc = longint'(m_b0) * x + longint'(m_b1) * m_x1 + longint'(m_b2) * m_x2
        - longint'(m_a1) * m_y1 - longint'(m_a2) * m_y2;
    r = (acc + 16384) >>> 15;
    if (r > 131071) r = 131071;
    if (r < -131072) r = -131072;
    e.y = int'(r);
    e.at_cyc = at_cyc;
    exp_q.push_back(e);
    m_x2 = m_x1; m_x1 = x;
    m_y2 = m_y1; m_y1 = int'(r);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sample_out_valid) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_output", sample_out, 0);
      end else begin
        e = exp_q.pop_front();
        check(sample_out == 18'(e.y), "sample_out", sample_out, e.y);
        check(cyc == e.at_cyc, "out_latency_cycle", cyc, e.at_cyc);
        $display("out: y=%0d expected=%0d cycle=%0d", sample_out, e.y, cyc);
      end
    end
  end

  task automatic pulse_coefs(input int b0, input int b1, input int b2, input int a1, input int a2);
    logic signed [17:0] c0, c1, c2, c3, c4;
    c0 = 18'(b0); c1 = 18'(b1); c2 = 18'(b2); c3 = 18'(a1); c4 = 18'(a2);
    @(negedge clk);
    coefs_flat   = {c4, c3, c2, c1, c0};
    coefs_update = 1'b1;
    m_b0 = b0; m_b1 = b1; m_b2 = b2; m_a1 = a1; m_a2 = a2;
    @(posedge clk); #1;
    coefs_update = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    state_clear = 1'b1;
    m_clear_req = 1;
    @(posedge clk); #1;
    state_clear = 1'b0;
  endtask

  task automatic send(input int x);
    int waited;
    @(negedge clk);
    waited = 0;
    while (!sample_in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!sample_in_ready) begin
      check(1'b0, "ready_timeout", 0, 1);
    end else begin
      sample_in       = 18'(x);
      sample_in_valid = 1'b1;
      model_accept(x, cyc + 7);
      $display("in: x=%0d cycle=%0d", x, cyc + 1);
      @(posedge clk); #1;
      sample_in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  function automatic int rand_sample();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  function automatic int rand_coef();
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 262143)) - 131072;
    return int'($urandom_range(0, 40000)) - 20000;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got cycle %0d, expected finish", cyc);
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(sample_in_ready == 1'b1, "reset_ready", sample_in_ready, 1);
    check(sample_out_valid == 1'b0, "reset_valid", sample_out_valid, 0);
    check(sample_out == 18'sd0, "reset_out", sample_out, 0);
    reset = 1'b1;

    // Passthrough
    pulse_coefs(32768, 0, 0, 0, 0);
    send(1000);
    send(-2000);
    drain();

    // Pure delay, then first-order feedback with cleared history
    pulse_coefs(0, 32768, 0, 0, 0);
    pulse_clear();
    send(5000); send(0); send(0);
    drain();
    pulse_coefs(32768, 0, 0, -16384, 0);
    pulse_clear();
    send(8192); send(0); send(0); send(0);
    drain();

    // Saturation and rounding
    pulse_coefs(98304, 0, 0, 0, 0);
    pulse_clear();
    send(100000); send(-100000);
    drain();
    pulse_coefs(16384, 0, 0, 0, 0);
    pulse_clear();
    send(3); send(-3);
    drain();

    // Coefficient update while a sample is in the MAC
    pulse_coefs(32768, 0, 0, 0, 0);
    pulse_clear();
    send(1000);
    pulse_coefs(65536, 0, 0, 0, 0);
    send(1000);
    drain();

    // Clear during MAC must still zero history for the following sample
    pulse_coefs(32768, 32768, 32768, 0, 0);
    send(4000);
    pulse_clear();
    send(700);
    drain();

    // Valid held high continuously: one acceptance per 7 cycles
    pulse_coefs(32768, 0, 0, 0, 0);
    pulse_clear();
    @(negedge clk);
    sample_in       = 18'sd1000;
    sample_in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check(sample_in_ready == 1'b1, "hs_ready_idle", sample_in_ready, 1);
      model_accept(1000, cyc + 7);
      $display("in: x=1000 (held) cycle=%0d", cyc + 1);
      for (int j = 0; j < 6; j++) begin
        @(negedge clk);
        check(sample_in_ready == 1'b0, "hs_ready_busy", sample_in_ready, 0);
      end
      @(negedge clk);
    end
    sample_in_valid = 1'b0;
    drain();

    // Reset in the middle of a MAC
    send(1000);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check(sample_out == 18'sd0, "midreset_out", sample_out, 0);
    check(sample_out_valid == 1'b0, "midreset_valid", sample_out_valid, 0);
    check(sample_in_ready == 1'b1, "midreset_ready", sample_in_ready, 1);
    repeat (10) @(negedge clk);
    send(1000);
    drain();

    // Randomized traffic with random coefficient swaps and clears
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) pulse_coefs(rand_coef(), rand_coef(), rand_coef(), rand_coef(), rand_coef());
      if ($urandom_range(0, 9) == 0) pulse_clear();
      send(rand_sample());
      if ($urandom_range(0, 5) == 0) pulse_coefs(rand_coef(), rand_coef(), rand_coef(), rand_coef(), rand_coef());
      if ($urandom_range(0, 11) == 0) pulse_clear();
    end
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
